// File: rtl/store_monitor_pkg.sv
// store_monitor_pkg: monitor state encoding and store-log entry width
package store_monitor_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;
  localparam int ENTRY_W = 64;
endpackage

// File: rtl/store_log_fifo.sv
// store_log_fifo: synchronous FIFO (push, pop, full, empty, sticky overflow) with registered pop output
module store_log_fifo import store_monitor_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic full, do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr + PW'(do_pop);
      rd_valid <= do_pop;
      if (do_pop) rd_data <= mem[rd_ptr[AW-1:0]];
      if (push && !do_push) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/store_monitor.sv
// store_monitor: store-port verdict/timeout FSM, saturating counters and store log; STORE_ALIGN_CHECK_EN adds misaligned-store fail
module store_monitor import store_monitor_pkg::*; #(
  parameter logic [31:0] PASS_ADDR = 32'd100,
  parameter logic [31:0] PASS_DATA = 32'd7,
  parameter int LOG_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWriteM,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [31:0]      rd_addr,
  output logic [31:0]      rd_data,
  output logic             log_empty,
  output logic             log_overflow,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
`ifdef STORE_ALIGN_CHECK_EN
  output logic             misaligned,
`endif
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] cycle_count
);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state, state_nxt;
  logic run, store, verdict, bad_align, tmo;
  assign run = state == RUN;
  assign store = run && MemWriteM;
  assign verdict = store && DataAdr == PASS_ADDR;
`ifdef STORE_ALIGN_CHECK_EN
  assign bad_align = store && DataAdr[1:0] != 2'b00;
`else
  assign bad_align = 1'b0;
`endif
  assign tmo = run && cycle_count == TMO_LAST;
  always_comb begin
    state_nxt = state == IDLE ? RUN :
                !run          ? state :
                verdict       ? (WriteData == PASS_DATA ? PASS : FAIL) :
                bad_align     ? FAIL :
                tmo           ? TIMEOUT : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
      timeout <= 1'b0;
      store_count <= '0;
      cycle_count <= '0;
`ifdef STORE_ALIGN_CHECK_EN
      misaligned <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      done <= state_nxt == PASS || state_nxt == FAIL || state_nxt == TIMEOUT;
      pass <= state_nxt == PASS;
      fail <= state_nxt == FAIL;
      timeout <= state_nxt == TIMEOUT;
      if (store && store_count != '1) store_count <= store_count + CNT_W'(1);
      if (run && cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
`ifdef STORE_ALIGN_CHECK_EN
      if (bad_align) misaligned <= 1'b1;
`endif
    end
  end
  store_log_fifo #(.DEPTH(LOG_DEPTH), .WIDTH(ENTRY_W)) u_log (
    .clk(clk),
    .reset(reset),
    .push(store),
    .push_data({DataAdr, WriteData}),
    .pop(rd_en),
    .rd_valid(rd_valid),
    .rd_data({rd_addr, rd_data}),
    .empty(log_empty),
    .overflow(log_overflow)
  );
endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor: scoreboard bench for store_monitor verdicts, timeout, counters and store log
module tb_store_monitor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic MemWriteM = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic rd_en = 1'b0;
  logic rd_valid, log_empty, log_overflow, done, pass, fail, timeout;
  logic [31:0] rd_addr, rd_data;
  logic [15:0] store_count, cycle_count;
`ifdef STORE_ALIGN_CHECK_EN
  logic misaligned;
`endif
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q [$];
  logic [63:0] head;
  always #5 clk = ~clk;
  store_monitor #(
    .PASS_ADDR(32'd100),
    .PASS_DATA(32'd7),
    .LOG_DEPTH(4),
    .TIMEOUT_CYCLES(20),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .MemWriteM(MemWriteM),
    .DataAdr(DataAdr),
    .WriteData(WriteData),
    .rd_en(rd_en),
    .rd_valid(rd_valid),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .log_empty(log_empty),
    .log_overflow(log_overflow),
    .done(done),
    .pass(pass),
    .fail(fail),
    .timeout(timeout),
`ifdef STORE_ALIGN_CHECK_EN
    .misaligned(misaligned),
`endif
    .store_count(store_count),
    .cycle_count(cycle_count)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic logged);
    MemWriteM = 1'b1;
    DataAdr = a;
    WriteData = d;
    if (logged) exp_q.push_back({a, d});
    tick();
    MemWriteM = 1'b0;
  endtask
  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask
  task automatic pop_n(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
  endtask
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) check("log_pending", 64'(exp_q.size()), 64'd1);
      else begin
        head = exp_q.pop_front();
        check("pop_entry", {rd_addr, rd_data}, head);
      end
    end
  end
  initial begin
    repeat (3) tick();
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_empty", 64'(log_empty), 64'd1);
    check("rst_store_count", 64'(store_count), 64'd0);
    check("rst_cycle_count", 64'(cycle_count), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    reset = 1'b0;
    tick();
    store(32'h60, 32'h11, 1'b1);
    check("pass_early", 64'(pass), 64'd0);
    store(32'h64, 32'h7, 1'b1);
    check("pass_set", 64'(pass), 64'd1);
    check("pass_done", 64'(done), 64'd1);
    check("pass_store_count", 64'(store_count), 64'd2);
    pop_n(2);
    check("pass_drained", 64'(log_empty), 64'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("empty_pop_valid", 64'(rd_valid), 64'd0);
    check("empty_pop_hold", {rd_addr, rd_data}, {32'h64, 32'h7});
    store(32'h64, 32'h5, 1'b0);
    check("pass_sticky", 64'(fail), 64'd0);
    check("pass_sticky_count", 64'(store_count), 64'd2);
    restart();
    store(32'h64, 32'h5, 1'b1);
    check("fail_set", 64'(fail), 64'd1);
    check("fail_done", 64'(done), 64'd1);
    check("fail_no_pass", 64'(pass), 64'd0);
    store(32'h64, 32'h7, 1'b0);
    check("fail_sticky", 64'(fail), 64'd1);
    check("fail_sticky_pass", 64'(pass), 64'd0);
    check("fail_store_count", 64'(store_count), 64'd1);
    pop_n(1);
    restart();
    repeat (19) tick();
    check("tmo_before", 64'(timeout), 64'd0);
    check("tmo_cc19", 64'(cycle_count), 64'd19);
    tick();
    check("tmo_set", 64'(timeout), 64'd1);
    check("tmo_done", 64'(done), 64'd1);
    repeat (3) tick();
    check("tmo_cc_sat", 64'(cycle_count), 64'd20);
    restart();
    repeat (19) tick();
    store(32'h64, 32'h7, 1'b1);
    check("race_pass", 64'(pass), 64'd1);
    check("race_no_tmo", 64'(timeout), 64'd0);
    pop_n(1);
    restart();
    for (int i = 0; i < 6; i++) store(32'h200 + 32'(4 * i), 32'(i + 1), i < 4);
    check("ovf_set", 64'(log_overflow), 64'd1);
    check("ovf_count", 64'(store_count), 64'd6);
    MemWriteM = 1'b1;
    DataAdr = 32'h300;
    WriteData = 32'hAA;
    rd_en = 1'b1;
    exp_q.push_back({32'h300, 32'hAA});
    tick();
    MemWriteM = 1'b0;
    repeat (2) tick();
    check("full_swap_occ3", 64'(log_empty), 64'd0);
    tick();
    check("full_swap_occ4", 64'(log_empty), 64'd0);
    tick();
    rd_en = 1'b0;
    check("full_swap_drained", 64'(log_empty), 64'd1);
    restart();
    for (int i = 0; i < 3; i++) store(32'h80 + 32'(4 * i), 32'(i), 1'b0);
    check("mid_store_count", 64'(store_count), 64'd3);
    reset = 1'b1;
    tick();
    check("mid_store_cleared", 64'(store_count), 64'd0);
    check("mid_cycle_cleared", 64'(cycle_count), 64'd0);
    check("mid_empty", 64'(log_empty), 64'd1);
    check("mid_rd_data", {rd_addr, rd_data}, 64'd0);
    check("mid_overflow", 64'(log_overflow), 64'd0);
    reset = 1'b0;
    tick();
    store(32'h64, 32'h7, 1'b1);
    check("mid_resume_pass", 64'(pass), 64'd1);
    check("mid_resume_count", 64'(store_count), 64'd1);
    pop_n(1);
`ifdef STORE_ALIGN_CHECK_EN
    restart();
    store(32'h62, 32'h1, 1'b1);
    check("align_flag", 64'(misaligned), 64'd1);
    check("align_fail", 64'(fail), 64'd1);
    pop_n(1);
`endif
    tick();
    check("q_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_monitor.md
Name: store_monitor

Overview:
Responder on the core's data-memory store port (MemWriteM / DataAdr / WriteData), instantiated next to top in simulation and FPGA bring-up.
- Decodes a mailbox address to declare program pass or fail.
- Enforces a cycle timeout.
- Counts stores.
- Logs recent stores into a small FIFO readable by a host or bench.

Parameters:
PASS_ADDR, 32'd100, mailbox address watched for the test verdict
PASS_DATA, 32'd7, value at PASS_ADDR meaning pass; any other value means fail
LOG_DEPTH, 8, store-log FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 10000, cycles in RUN before TIMEOUT is declared
CNT_W, 16, width of store_count and cycle_count

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high
MemWriteM  input  1  store strobe from the core, one store per asserted cycle
DataAdr  input  32  store byte address
WriteData  input  32  store data
rd_en  input  1  pop request for the store log
rd_valid  output  1  rd_addr/rd_data valid this cycle (one-cycle pulse)
rd_addr  output  32  logged address
rd_data  output  32  logged data
log_empty  output  1  FIFO empty
log_overflow  output  1  sticky; a store was dropped because the FIFO was full
done  output  1  in PASS, FAIL or TIMEOUT
pass  output  1  in PASS
fail  output  1  in FAIL
timeout  output  1  in TIMEOUT
store_count  output  CNT_W  stores accepted in RUN, saturating at all-ones
cycle_count  output  CNT_W  cycles spent in RUN, saturating

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All outputs are 0, except log_empty=1.
  - FIFO pointers and counters are cleared.
  - Reset asserted mid-operation discards all state on the next edge.
- State transitions:
  - IDLE -> RUN on the first edge with reset=0.
  - RUN -> PASS on MemWriteM=1 with DataAdr==PASS_ADDR and WriteData==PASS_DATA.
  - RUN -> FAIL on MemWriteM=1 with DataAdr==PASS_ADDR and WriteData!=PASS_DATA.
  - RUN -> TIMEOUT when cycle_count==TIMEOUT_CYCLES-1 and no verdict store occurs that cycle. A verdict store wins over timeout in the same cycle.
  - PASS, FAIL and TIMEOUT are sticky until reset.
  - Flags are registered and assert one cycle after the triggering edge.
- Stores in RUN, including the verdict store:
  - store_count increments.
  - {DataAdr, WriteData} is pushed to the log.
  - Stores outside RUN are ignored.
- Pop:
  - rd_en=1 with FIFO not empty pops the head.
  - rd_addr/rd_data are registered, and rd_valid=1 on the next cycle only.
  - rd_en on an empty FIFO is ignored; rd_valid stays 0 and the data outputs hold their last value.
  - Pops remain legal in terminal states.
- Full FIFO:
  - Push with no pop drops the new entry and sets log_overflow.
  - Simultaneous push and pop while full: both are accepted and occupancy is unchanged.
  - Simultaneous push and pop while empty: the push is stored and the pop is ignored.
- Pointers are log2(LOG_DEPTH)+1 bits with natural wrap. Full/empty come from the MSB compare.
- Counters saturate and never wrap.

Optional Feature:
STORE_ALIGN_CHECK_EN.
- When defined:
  - A RUN store with DataAdr[1:0]!=0 moves RUN -> FAIL (the FAIL state, same encoding).
  - An extra output misaligned (1 bit, sticky) is set.
  - Priority: verdict > misaligned > timeout.
- When undefined:
  - The port is absent.
  - Alignment is not checked.

Decomposition:
- Package store_monitor_pkg holds:
  - state enum/localparams IDLE=3'd0, RUN=3'd1, PASS=3'd2, FAIL=3'd3, TIMEOUT=3'd4;
  - the log entry width constant (64).
- One sub-module, store_log_fifo: synchronous FIFO with push, pop, full, empty and overflow, parameterised by depth and width.
- The FSM and counters stay in store_monitor.

Test Plan:
- Reset held 3 cycles, then released; program stores (0x60, 0x11), (0x64, 0x7) → pass=1 one cycle after the second store; store_count=2; two pops return 0x60/0x11, then 0x64/0x7.
- Store (0x64, 0x5) → fail=1, done=1, pass=0; a later store (0x64, 0x7) does not change the verdict.
- TIMEOUT_CYCLES=20 with no stores → timeout=1 after exactly 20 RUN cycles; cycle_count saturates at 20.
- LOG_DEPTH=4, 6 non-verdict stores without pops → entries 1–4 retained, log_overflow=1; push+pop on the same cycle while full → occupancy stays 4.
- Reset asserted mid-RUN after 3 stores → all outputs cleared next edge, log_empty=1; RUN resumes after release.
- With STORE_ALIGN_CHECK_EN: store (0x62, 0x1) → misaligned=1, fail=1. Verdict store and timeout on the same cycle → verdict wins.
